// File: rtl/exu_operand_buffer_if.sv
// Handshake bundle between the IDU, the EXU operand buffer and the ALU.
// The slave view belongs to the buffer; the master view drives it.
interface exu_operand_buffer_if #(
    parameter int BW = 32,
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_pc;
    logic [BW-1:0] in_rs1_data;
    logic [BW-1:0] in_rs2_data;
    logic [BW-1:0] in_imm;
    logic          in_src1_pc;
    logic          in_src2_imm;
    logic [3:0]    in_alu_op;
    logic [RW-1:0] in_rd;
    logic          in_rd_wen;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_d1;
    logic [BW-1:0] out_d2;
    logic [3:0]    out_choice;
    logic [BW-1:0] out_pc;
    logic [RW-1:0] out_rd;
    logic          out_rd_wen;
    logic [31:0]   stall_cnt;

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_src1_pc, in_src2_imm, in_alu_op, in_rd, in_rd_wen,
               flush, out_ready,
        input  in_ready, out_valid, out_d1, out_d2, out_choice, out_pc,
               out_rd, out_rd_wen, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_src1_pc, in_src2_imm, in_alu_op, in_rd, in_rd_wen,
               flush, out_ready,
        output in_ready, out_valid, out_d1, out_d2, out_choice, out_pc,
               out_rd, out_rd_wen, stall_cnt
    );
endinterface

// File: rtl/exu_operand_buffer.sv
// EXU operand buffer: muxes operands at capture and holds them in a
// two-entry skid buffer (main entry M drives the ALU, skid entry S absorbs
// one extra instruction under backpressure). Also counts stall cycles.
//
// state    | meaning
// ST_EMPTY | no valid entry
// ST_ONE   | M valid, S empty
// ST_TWO   | M and S valid, input blocked
module exu_operand_buffer #(
    parameter int BW = 32,
    parameter int RW = 4
) (
    input  logic               clk,
    input  logic               rst,
    exu_operand_buffer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [BW-1:0] pc;
        logic [BW-1:0] d1;
        logic [BW-1:0] d2;
        logic [3:0]    op;
        logic [RW-1:0] rd;
        logic          wen;
    } entry_t;

    state_t      r_state;
    logic        r_m_valid;
    logic        r_s_valid;
    entry_t      r_m;
    entry_t      r_s;
    logic [31:0] r_stall_cnt;

    entry_t      w_in;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_consume;

    // Operands are selected here so the stored entries carry final ALU inputs.
    always_comb begin
        w_in     = '0;
        w_in.pc  = bus.in_pc;
        w_in.d1  = bus.in_src1_pc  ? bus.in_pc  : bus.in_rs1_data;
        w_in.d2  = bus.in_src2_imm ? bus.in_imm : bus.in_rs2_data;
        w_in.op  = bus.in_alu_op;
        w_in.rd  = bus.in_rd;
        w_in.wen = bus.in_rd_wen;
    end

    // Ready depends only on registered occupancy and reset, never on out_ready.
    assign w_in_ready = ~r_s_valid & ~rst;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_consume  = r_m_valid & bus.out_ready;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_m_valid;
    assign bus.out_d1     = r_m.d1;
    assign bus.out_d2     = r_m.d2;
    assign bus.out_choice = r_m.op;
    assign bus.out_pc     = r_m.pc;
    assign bus.out_rd     = r_m.rd;
    assign bus.out_rd_wen = r_m.wen;
    assign bus.stall_cnt  = r_stall_cnt;

    // Occupancy FSM, entry storage and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_m_valid   <= 1'b0;
            r_s_valid   <= 1'b0;
            r_m         <= '0;
            r_s         <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Counting is independent of flush so redirects do not hide stalls.
            if (r_m_valid && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end

            if (bus.flush) begin
                r_state   <= ST_EMPTY;
                r_m_valid <= 1'b0;
                r_s_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            r_m       <= w_in;
                            r_m_valid <= 1'b1;
                            r_state   <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_consume && w_accept) begin
                            r_m <= w_in;
                        end else if (w_consume) begin
                            r_m_valid <= 1'b0;
                            r_state   <= ST_EMPTY;
                        end else if (w_accept) begin
                            r_s       <= w_in;
                            r_s_valid <= 1'b1;
                            r_state   <= ST_TWO;
                        end
                    end
                    ST_TWO: begin
                        if (w_consume) begin
                            r_m       <= r_s;
                            r_s_valid <= 1'b0;
                            r_state   <= ST_ONE;
                        end
                    end
                    default: begin
                        r_m_valid <= 1'b0;
                        r_s_valid <= 1'b0;
                        r_state   <= ST_EMPTY;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exu_operand_buffer.sv
// Bench for exu_operand_buffer: a capacity-two FIFO model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_exu_operand_buffer;
    localparam int BW = 32;
    localparam int RW = 4;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    logic clk = 1'b0;
    logic rst;

    exu_operand_buffer_if #(.BW(BW), .RW(RW)) bus();

    exu_operand_buffer #(.BW(BW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic        wen;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_stall = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a strict FIFO of depth two, updated at each rising edge.
    initial begin
        ent_t e;
        bit   acc;
        bit   con;
        forever begin
            @(posedge clk);
            acc   = bus.in_valid && !rst && (mq.size() < 2);
            con   = (mq.size() > 0) && bus.out_ready;
            e.d1  = bus.in_src1_pc  ? bus.in_pc  : bus.in_rs1_data;
            e.d2  = bus.in_src2_imm ? bus.in_imm : bus.in_rs2_data;
            e.pc  = bus.in_pc;
            e.op  = bus.in_alu_op;
            e.rd  = bus.in_rd;
            e.wen = bus.in_rd_wen;
            if (rst) begin
                mq.delete();
                m_stall = 32'd0;
            end else begin
                if ((mq.size() > 0) && !bus.out_ready && (m_stall != 32'hFFFF_FFFF))
                    m_stall = m_stall + 32'd1;
                if (bus.flush) begin
                    mq.delete();
                end else begin
                    if (con) void'(mq.pop_front());
                    if (acc) mq.push_back(e);
                end
            end
            #1;
            check("out_valid", bus.out_valid, mq.size() > 0);
            check("in_ready", bus.in_ready, !rst && (mq.size() < 2));
            check("stall_cnt", bus.stall_cnt, m_stall);
            if (mq.size() > 0) begin
                check("out_d1", bus.out_d1, mq[0].d1);
                check("out_d2", bus.out_d2, mq[0].d2);
                check("out_pc", bus.out_pc, mq[0].pc);
                check("out_choice", bus.out_choice, mq[0].op);
                check("out_rd", bus.out_rd, mq[0].rd);
                check("out_rd_wen", bus.out_rd_wen, mq[0].wen);
            end
        end
    end

    task automatic idle();
        bus.in_valid    = 1'b0;
        bus.in_pc       = '0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.in_imm      = '0;
        bus.in_src1_pc  = 1'b0;
        bus.in_src2_imm = 1'b0;
        bus.in_alu_op   = '0;
        bus.in_rd       = '0;
        bus.in_rd_wen   = 1'b0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm,
                             input logic s1pc, input logic s2imm,
                             input logic [3:0] op, input logic [3:0] rd, input logic wen);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        bus.in_imm      = imm;
        bus.in_src1_pc  = s1pc;
        bus.in_src2_imm = s2imm;
        bus.in_alu_op   = op;
        bus.in_rd       = rd;
        bus.in_rd_wen   = wen;
    endtask

    // Offer an instruction until it is taken; called just after a falling edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm,
                        input logic s1pc, input logic s2imm,
                        input logic [3:0] op, input logic [3:0] rd, input logic wen);
        bit done;
        bit r;
        done = 1'b0;
        set_instr(pc, rs1, rs2, imm, s1pc, s2imm, op, rd, wen);
        for (int i = 0; i < 20 && !done; i++) begin
            r = bus.in_ready;
            @(negedge clk);
            done = r;
        end
        if (!done) check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        idle();

        // Reset values
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_d1", bus.out_d1, 0);
        check("rst_d2", bus.out_d2, 0);
        check("rst_pc", bus.out_pc, 0);
        check("rst_choice", bus.out_choice, 0);
        check("rst_rd", bus.out_rd, 0);
        check("rst_wen", bus.out_rd_wen, 0);
        check("rst_stall", bus.stall_cnt, 0);
        @(negedge clk);

        // Back-to-back stream at full throughput
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h100 + 32'(4 * i), 32'd5, 32'hDEAD, 32'd3, 1'b0, 1'b1, ALU_ADD, 4'(i + 1), 1'b1);
            check("b2b_valid", bus.out_valid, 1);
            check("b2b_d1", bus.out_d1, 32'd5);
            check("b2b_d2", bus.out_d2, 32'd3);
            check("b2b_choice", bus.out_choice, ALU_ADD);
            check("b2b_pc", bus.out_pc, 32'h100 + 32'(4 * i));
        end
        @(negedge clk);

        // Backpressure fill: two accepted, third blocked
        bus.out_ready = 1'b0;
        send(32'h8000_0000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, ALU_ADD, 4'd1, 1'b1);
        send(32'h8000_0004, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, ALU_ADD, 4'd2, 1'b1);
        check("bp_in_ready", bus.in_ready, 0);
        set_instr(32'h8000_0008, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0, ALU_ADD, 4'd3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("bp_stall", bus.stall_cnt, 32'd3);
        check("bp_hold_pc", bus.out_pc, 32'h8000_0000);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_order1", bus.out_pc, 32'h8000_0004);
        @(negedge clk);
        check("bp_order2", bus.out_pc, 32'h8000_0008);
        idle();
        @(negedge clk);
        check("bp_drained", bus.out_valid, 0);

        // Operand select: PC as d1, rs2 as d2
        bus.out_ready = 1'b0;
        send(32'h8000_0010, 32'h1111_1111, 32'hFFFF_FFFF, 32'h7, 1'b1, 1'b0, ALU_SUB, 4'd2, 1'b1);
        check("sel_d1", bus.out_d1, 32'h8000_0010);
        check("sel_d2", bus.out_d2, 32'hFFFF_FFFF);
        check("sel_choice", bus.out_choice, ALU_SUB);

        // Flush while TWO with an instruction offered
        send(32'h8000_0014, 32'd9, 32'd9, 32'd9, 1'b0, 1'b0, ALU_ADD, 4'd3, 1'b0);
        check("fl_two_in_ready", bus.in_ready, 0);
        set_instr(32'h8000_0018, 32'd7, 32'd7, 32'd7, 1'b0, 1'b0, ALU_ADD, 4'd4, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        idle();
        check("fl_out_valid", bus.out_valid, 0);
        check("fl_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Flush while EMPTY discards a same-cycle accept
        set_instr(32'h9000_0000, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0, ALU_ADD, 4'd5, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        idle();
        check("fl_acc_out_valid", bus.out_valid, 0);
        @(negedge clk);

        // Reset mid-stream while TWO
        bus.out_ready = 1'b0;
        send(32'hA000_0000, 32'h55, 32'h66, 32'h77, 1'b0, 1'b1, ALU_SUB, 4'd6, 1'b1);
        send(32'hA000_0004, 32'h88, 32'h99, 32'hAA, 1'b1, 1'b0, ALU_ADD, 4'd7, 1'b1);
        check("rs_two_in_ready", bus.in_ready, 0);
        set_instr(32'hA000_0008, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, ALU_ADD, 4'd8, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rs_out_valid", bus.out_valid, 0);
        check("rs_d1", bus.out_d1, 0);
        check("rs_d2", bus.out_d2, 0);
        check("rs_pc", bus.out_pc, 0);
        check("rs_choice", bus.out_choice, 0);
        check("rs_rd", bus.out_rd, 0);
        check("rs_wen", bus.out_rd_wen, 0);
        check("rs_stall", bus.stall_cnt, 0);
        check("rs_in_ready_hi", bus.in_ready, 0);
        rst = 1'b0;
        idle();
        #1;
        check("rs_in_ready_lo", bus.in_ready, 1);
        @(negedge clk);

        // Stall counter saturation from a preloaded near-max value
        m_stall = 32'hFFFF_FFFE;
        dut.r_stall_cnt = 32'hFFFF_FFFE;
        send(32'hB000_0000, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, ALU_ADD, 4'd9, 1'b1);
        check("sat_pre", bus.stall_cnt, 32'hFFFF_FFFE);
        @(negedge clk);
        check("sat_1", bus.stall_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        check("sat_3", bus.stall_cnt, 32'hFFFF_FFFF);

        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("end_empty", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
